// File: rtl/id_ctrl_stage_pkg.sv
// id_ctrl_stage_pkg: shared opcode/funct codes, ALU op encodings, FSM states and control bundle
package id_ctrl_stage_pkg;
    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2b;
    localparam logic [5:0] FN_MULT  = 6'h18;
    localparam logic [5:0] FN_DIV   = 6'h1a;
    localparam logic [5:0] FN_ADD   = 6'h20;
    localparam logic [5:0] FN_SUB   = 6'h22;
    localparam logic [5:0] FN_AND   = 6'h24;
    localparam logic [5:0] FN_OR    = 6'h25;
    localparam logic [5:0] FN_SLT   = 6'h2a;
    localparam int ALUOP_ADD  = 0;
    localparam int ALUOP_SUB  = 1;
    localparam int ALUOP_AND  = 2;
    localparam int ALUOP_OR   = 3;
    localparam int ALUOP_SLT  = 4;
    localparam int ALUOP_MULT = 5;
    localparam int ALUOP_DIV  = 6;
    localparam int ALUOP_PASS = 7;
    typedef enum logic {IDLE, BUSY} state_t;
    typedef struct packed {
        logic regwrite;
        logic memtoreg;
        logic memread;
        logic memwrite;
        logic isbranch;
        logic isjump;
        logic regdst;
        logic alusrc;
        logic illegal;
    } ctrl_t;
endpackage

// File: rtl/id_ctrl_stage_if.sv
// id_ctrl_stage_if: IF/ID instruction channel, EX hazard inputs and registered ID/EX control slice
interface id_ctrl_stage_if #(
    parameter int REG_ADDR_W = 5,
    parameter int ALUOP_W    = 4
);
    logic                  in_valid;
    logic                  in_ready;
    logic [5:0]            opcode;
    logic [5:0]            funct;
    logic [REG_ADDR_W-1:0] rs;
    logic [REG_ADDR_W-1:0] rt;
    logic                  ex_memread;
    logic [REG_ADDR_W-1:0] ex_rt;
    logic                  flush;
    logic                  out_valid;
    logic                  out_ready;
    logic                  regwrite;
    logic                  memtoreg;
    logic                  memread;
    logic                  memwrite;
    logic                  isbranch;
    logic                  isjump;
    logic                  regdst;
    logic                  alusrc;
    logic [ALUOP_W-1:0]    aluop;
    logic                  illegal;
    modport master (
        output in_valid, opcode, funct, rs, rt, ex_memread, ex_rt, flush, out_ready,
        input  in_ready, out_valid, regwrite, memtoreg, memread, memwrite, isbranch, isjump,
               regdst, alusrc, aluop, illegal
    );
    modport slave (
        input  in_valid, opcode, funct, rs, rt, ex_memread, ex_rt, flush, out_ready,
        output in_ready, out_valid, regwrite, memtoreg, memread, memwrite, isbranch, isjump,
               regdst, alusrc, aluop, illegal
    );
endinterface

// File: rtl/id_ctrl_stage_decode.sv
// id_ctrl_stage_decode: pure combinational opcode/funct to control bundle decoder
module id_ctrl_stage_decode
    import id_ctrl_stage_pkg::*;
#(
    parameter int ALUOP_W = 4
) (
    input  logic [5:0]         opcode,
    input  logic [5:0]         funct,
    output ctrl_t              ctrl,
    output logic [ALUOP_W-1:0] aluop,
    output logic               uses_rt,
    output logic               muldiv
);
    // unknown encodings fall through to an all-zero bundle with only illegal set
    always_comb begin
        ctrl    = '0;
        aluop   = ALUOP_W'(ALUOP_PASS);
        muldiv  = 1'b0;
        uses_rt = (opcode == OP_RTYPE) || (opcode == OP_SW) || (opcode == OP_BEQ) || (opcode == OP_BNE);
        case (opcode)
            OP_RTYPE: begin
                case (funct)
                    FN_ADD:  begin ctrl.regwrite = 1'b1; ctrl.regdst = 1'b1; aluop = ALUOP_W'(ALUOP_ADD); end
                    FN_SUB:  begin ctrl.regwrite = 1'b1; ctrl.regdst = 1'b1; aluop = ALUOP_W'(ALUOP_SUB); end
                    FN_AND:  begin ctrl.regwrite = 1'b1; ctrl.regdst = 1'b1; aluop = ALUOP_W'(ALUOP_AND); end
                    FN_OR:   begin ctrl.regwrite = 1'b1; ctrl.regdst = 1'b1; aluop = ALUOP_W'(ALUOP_OR); end
                    FN_SLT:  begin ctrl.regwrite = 1'b1; ctrl.regdst = 1'b1; aluop = ALUOP_W'(ALUOP_SLT); end
                    FN_MULT: begin muldiv = 1'b1; aluop = ALUOP_W'(ALUOP_MULT); end
                    FN_DIV:  begin muldiv = 1'b1; aluop = ALUOP_W'(ALUOP_DIV); end
                    default: ctrl.illegal = 1'b1;
                endcase
            end
            OP_ADDI: begin ctrl.regwrite = 1'b1; ctrl.alusrc = 1'b1; aluop = ALUOP_W'(ALUOP_ADD); end
            OP_LW: begin
                ctrl.regwrite = 1'b1;
                ctrl.memtoreg = 1'b1;
                ctrl.memread  = 1'b1;
                ctrl.alusrc   = 1'b1;
                aluop         = ALUOP_W'(ALUOP_ADD);
            end
            OP_SW:   begin ctrl.memwrite = 1'b1; ctrl.alusrc = 1'b1; aluop = ALUOP_W'(ALUOP_ADD); end
            OP_BEQ:  begin ctrl.isbranch = 1'b1; aluop = ALUOP_W'(ALUOP_SUB); end
            OP_BNE:  begin ctrl.isbranch = 1'b1; aluop = ALUOP_W'(ALUOP_SUB); end
            OP_J:    ctrl.isjump = 1'b1;
            default: ctrl.illegal = 1'b1;
        endcase
    end
endmodule

// File: rtl/id_ctrl_stage.sv
// id_ctrl_stage: ID/EX control slice with handshake, load-use stall, MULT/DIV hold and flush
module id_ctrl_stage
    import id_ctrl_stage_pkg::*;
#(
    parameter int REG_ADDR_W = 5,
    parameter int ALUOP_W    = 4,
    parameter int MULDIV_LAT = 4,
    parameter int HAZARD_EN  = 1
) (
    input logic           clk,
    input logic           reset,
    id_ctrl_stage_if.slave bus
);
    localparam int CNT_W = $clog2(MULDIV_LAT + 1);
    localparam bit HOLD  = MULDIV_LAT > 1;
    ctrl_t              dec_ctrl;
    ctrl_t              ctrl_q;
    logic [ALUOP_W-1:0] dec_aluop;
    logic [ALUOP_W-1:0] aluop_q;
    logic               uses_rt;
    logic               muldiv;
    logic               hazard;
    logic               in_ready;
    logic               accept;
    logic               out_free;
    logic               issue;
    logic               nxt_valid;
    logic               out_valid_q;
    state_t             state;
    state_t             nxt_state;
    logic [CNT_W-1:0]   cnt;
    logic [CNT_W-1:0]   nxt_cnt;

    id_ctrl_stage_decode #(.ALUOP_W(ALUOP_W)) u_decode (
        .opcode  (bus.opcode),
        .funct   (bus.funct),
        .ctrl    (dec_ctrl),
        .aluop   (dec_aluop),
        .uses_rt (uses_rt),
        .muldiv  (muldiv)
    );

    assign hazard = (HAZARD_EN != 0) && bus.ex_memread && (bus.ex_rt != '0) &&
                    ((bus.ex_rt == bus.rs) || (uses_rt && (bus.ex_rt == bus.rt)));

    // handshake and output-valid control; flush overrides everything
    always_comb begin
        out_free  = !out_valid_q || bus.out_ready;
        in_ready  = (state == IDLE) && !hazard && !bus.flush && out_free;
        accept    = bus.in_valid && in_ready;
        issue     = (state == BUSY) && (cnt == CNT_W'(1)) && out_free;
        nxt_valid = bus.flush ? 1'b0 :
                    ((accept && !(muldiv && HOLD)) || issue) ? 1'b1 :
                    out_valid_q && !bus.out_ready;
    end

    // next state and MULT/DIV countdown; a blocked issue parks the counter at 1
    always_comb begin
        nxt_state = bus.flush ? IDLE :
                    (state == IDLE) ? ((accept && muldiv && HOLD) ? BUSY : IDLE) :
                    issue ? IDLE : BUSY;
        nxt_cnt   = bus.flush ? '0 :
                    (state == IDLE) ? ((accept && muldiv && HOLD) ? CNT_W'(MULDIV_LAT - 1) : '0) :
                    issue ? '0 :
                    (cnt > CNT_W'(1)) ? cnt - CNT_W'(1) : cnt;
    end

    // state, counter and bundle registers; the bundle only loads on accept so a held output stays stable
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            cnt         <= '0;
            out_valid_q <= 1'b0;
            ctrl_q      <= '0;
            aluop_q     <= '0;
        end else begin
            state       <= nxt_state;
            cnt         <= nxt_cnt;
            out_valid_q <= nxt_valid;
            if (accept) begin
                ctrl_q  <= dec_ctrl;
                aluop_q <= dec_aluop;
            end
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid_q;
    assign bus.regwrite  = ctrl_q.regwrite;
    assign bus.memtoreg  = ctrl_q.memtoreg;
    assign bus.memread   = ctrl_q.memread;
    assign bus.memwrite  = ctrl_q.memwrite;
    assign bus.isbranch  = ctrl_q.isbranch;
    assign bus.isjump    = ctrl_q.isjump;
    assign bus.regdst    = ctrl_q.regdst;
    assign bus.alusrc    = ctrl_q.alusrc;
    assign bus.aluop     = aluop_q;
    assign bus.illegal   = ctrl_q.illegal;
endmodule

// File: tb/tb_id_ctrl_stage.sv
// tb_id_ctrl_stage: table-driven decode vectors plus hand sequences for stall, hold, MULT/DIV and flush
module tb_id_ctrl_stage;
    import id_ctrl_stage_pkg::*;

    typedef struct {
        string      name;
        logic [5:0] op;
        logic [5:0] fn;
        logic [8:0] flg;
        logic [3:0] alu;
    } vec_t;

    logic clk = 1'b0;
    logic reset;
    int   n_cmp = 0;
    int   n_err = 0;
    vec_t vq[$];

    always #5 clk = ~clk;

    id_ctrl_stage_if #(.REG_ADDR_W(5), .ALUOP_W(4)) bus ();

    id_ctrl_stage #(.REG_ADDR_W(5), .ALUOP_W(4), .MULDIV_LAT(4), .HAZARD_EN(1)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    // flag order: regwrite memtoreg memread memwrite isbranch isjump regdst alusrc illegal
    localparam logic [8:0] F_R    = 9'b100000100;
    localparam logic [8:0] F_ADDI = 9'b100000010;
    localparam logic [8:0] F_LW   = 9'b111000010;
    localparam logic [8:0] F_SW   = 9'b000100010;
    localparam logic [8:0] F_BR   = 9'b000010000;
    localparam logic [8:0] F_J    = 9'b000001000;
    localparam logic [8:0] F_ILL  = 9'b000000001;

    function automatic logic [8:0] flags();
        return {bus.regwrite, bus.memtoreg, bus.memread, bus.memwrite, bus.isbranch,
                bus.isjump, bus.regdst, bus.alusrc, bus.illegal};
    endfunction

    function automatic vec_t mk(string n, logic [5:0] op, logic [5:0] fn, logic [8:0] f, int a);
        vec_t v;
        v.name = n;
        v.op   = op;
        v.fn   = fn;
        v.flg  = f;
        v.alu  = 4'(a);
        return v;
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(logic v, logic [5:0] op, logic [5:0] fn, logic [4:0] rs, logic [4:0] rt);
        bus.in_valid = v;
        bus.opcode   = op;
        bus.funct    = fn;
        bus.rs       = rs;
        bus.rt       = rt;
        #1;
    endtask

    initial begin
        vq.push_back(mk("add",   6'h00, 6'h20, F_R,    ALUOP_ADD));
        vq.push_back(mk("sub",   6'h00, 6'h22, F_R,    ALUOP_SUB));
        vq.push_back(mk("and",   6'h00, 6'h24, F_R,    ALUOP_AND));
        vq.push_back(mk("or",    6'h00, 6'h25, F_R,    ALUOP_OR));
        vq.push_back(mk("slt",   6'h00, 6'h2a, F_R,    ALUOP_SLT));
        vq.push_back(mk("addi",  6'h08, 6'h00, F_ADDI, ALUOP_ADD));
        vq.push_back(mk("lw",    6'h23, 6'h00, F_LW,   ALUOP_ADD));
        vq.push_back(mk("sw",    6'h2b, 6'h00, F_SW,   ALUOP_ADD));
        vq.push_back(mk("beq",   6'h04, 6'h00, F_BR,   ALUOP_SUB));
        vq.push_back(mk("bne",   6'h05, 6'h00, F_BR,   ALUOP_SUB));
        vq.push_back(mk("j",     6'h02, 6'h00, F_J,    ALUOP_PASS));
        vq.push_back(mk("op3f",  6'h3f, 6'h00, F_ILL,  ALUOP_PASS));
        vq.push_back(mk("fn3f",  6'h00, 6'h3f, F_ILL,  ALUOP_PASS));

        reset          = 1'b1;
        bus.ex_memread = 1'b0;
        bus.ex_rt      = '0;
        bus.flush      = 1'b0;
        bus.out_ready  = 1'b1;
        drive(1'b0, 6'h00, 6'h00, 5'd0, 5'd0);
        repeat (3) step();
        chk("reset_out_valid", 32'(bus.out_valid), 0);
        chk("reset_flags", 32'(flags()), 0);
        chk("reset_aluop", 32'(bus.aluop), 0);
        reset = 1'b0;
        #1;
        chk("reset_in_ready", 32'(bus.in_ready), 1);

        // back-to-back accepts with out_ready high: each new bundle replaces the old with no gap
        foreach (vq[i]) begin
            drive(1'b1, vq[i].op, vq[i].fn, 5'd1, 5'd2);
            chk({vq[i].name, "_in_ready"}, 32'(bus.in_ready), 1);
            step();
            bus.in_valid = 1'b0;
            chk({vq[i].name, "_out_valid"}, 32'(bus.out_valid), 1);
            chk({vq[i].name, "_flags"}, 32'(flags()), 32'(vq[i].flg));
            chk({vq[i].name, "_aluop"}, 32'(bus.aluop), 32'(vq[i].alu));
        end
        step();
        chk("bubble_after_table", 32'(bus.out_valid), 0);

        // load-use hazards
        bus.ex_memread = 1'b1;
        bus.ex_rt      = 5'd5;
        drive(1'b1, OP_RTYPE, FN_ADD, 5'd5, 5'd2);
        chk("haz_rs_ready", 32'(bus.in_ready), 0);
        step();
        chk("haz_rs_out_valid", 32'(bus.out_valid), 0);
        chk("haz_rs_ready_held", 32'(bus.in_ready), 0);
        drive(1'b1, OP_RTYPE, FN_ADD, 5'd1, 5'd5);
        chk("haz_rt_rtype", 32'(bus.in_ready), 0);
        drive(1'b1, OP_SW, 6'h00, 5'd1, 5'd5);
        chk("haz_rt_sw", 32'(bus.in_ready), 0);
        drive(1'b1, OP_ADDI, 6'h00, 5'd1, 5'd5);
        chk("nohaz_rt_addi", 32'(bus.in_ready), 1);
        drive(1'b1, OP_RTYPE, FN_ADD, 5'd5, 5'd2);
        bus.ex_memread = 1'b0;
        #1;
        chk("haz_release_ready", 32'(bus.in_ready), 1);
        step();
        bus.in_valid = 1'b0;
        chk("haz_release_valid", 32'(bus.out_valid), 1);
        chk("haz_release_aluop", 32'(bus.aluop), ALUOP_ADD);
        step();
        bus.ex_memread = 1'b1;
        bus.ex_rt      = 5'd0;
        drive(1'b1, OP_RTYPE, FN_ADD, 5'd0, 5'd0);
        chk("haz_rt0_ready", 32'(bus.in_ready), 1);
        step();
        bus.in_valid   = 1'b0;
        bus.ex_memread = 1'b0;
        chk("haz_rt0_valid", 32'(bus.out_valid), 1);
        step();

        // MULT and DIV occupy the stage for four cycles from accept to out_valid
        for (int k = 0; k < 2; k++) begin
            drive(1'b1, OP_RTYPE, (k == 0) ? FN_MULT : FN_DIV, 5'd1, 5'd2);
            chk("md_accept_ready", 32'(bus.in_ready), 1);
            step();
            bus.in_valid = 1'b0;
            for (int c = 1; c < 4; c++) begin
                chk("md_busy_valid", 32'(bus.out_valid), 0);
                chk("md_busy_ready", 32'(bus.in_ready), 0);
                step();
            end
            chk("md_issue_valid", 32'(bus.out_valid), 1);
            chk("md_issue_aluop", 32'(bus.aluop), (k == 0) ? ALUOP_MULT : ALUOP_DIV);
            chk("md_issue_flags", 32'(flags()), 0);
            chk("md_issue_ready", 32'(bus.in_ready), 1);
            step();
            chk("md_bubble", 32'(bus.out_valid), 0);
        end

        // output hold with LW, then SW accepted in the same cycle the LW drains
        drive(1'b1, OP_LW, 6'h00, 5'd1, 5'd2);
        step();
        bus.out_ready = 1'b0;
        drive(1'b1, OP_SW, 6'h00, 5'd3, 5'd4);
        for (int c = 0; c < 3; c++) begin
            chk("hold_valid", 32'(bus.out_valid), 1);
            chk("hold_flags", 32'(flags()), 32'(F_LW));
            chk("hold_ready", 32'(bus.in_ready), 0);
            step();
        end
        chk("hold_end_flags", 32'(flags()), 32'(F_LW));
        bus.out_ready = 1'b1;
        #1;
        chk("drain_ready", 32'(bus.in_ready), 1);
        step();
        bus.in_valid = 1'b0;
        chk("sw_valid", 32'(bus.out_valid), 1);
        chk("sw_flags", 32'(flags()), 32'(F_SW));
        step();

        // flush mid-BUSY kills the MULT; the ADD offered alongside the flush is ignored
        drive(1'b1, OP_RTYPE, FN_MULT, 5'd1, 5'd2);
        step();
        bus.in_valid = 1'b0;
        step();
        bus.flush = 1'b1;
        drive(1'b1, OP_RTYPE, FN_ADD, 5'd1, 5'd2);
        chk("flush_ready", 32'(bus.in_ready), 0);
        step();
        bus.flush    = 1'b0;
        bus.in_valid = 1'b0;
        #1;
        chk("flush_valid", 32'(bus.out_valid), 0);
        chk("flush_idle_ready", 32'(bus.in_ready), 1);
        for (int c = 0; c < 5; c++) begin
            step();
            chk("flush_no_late_issue", 32'(bus.out_valid), 0);
        end

        // flush while a bundle is held toward EX
        drive(1'b1, OP_LW, 6'h00, 5'd1, 5'd2);
        step();
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        chk("flush_hold_pre", 32'(bus.out_valid), 1);
        bus.flush = 1'b1;
        step();
        bus.flush = 1'b0;
        #1;
        chk("flush_hold_valid", 32'(bus.out_valid), 0);
        chk("flush_hold_ready", 32'(bus.in_ready), 1);
        bus.out_ready = 1'b1;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
